led_fade_driver: RTL

- Output stage between a logical LED pattern source (blinker, sequencer) and the board LED pins.
- Converts each on/off pattern bit into a PWM-driven LED whose brightness ramps smoothly up on turn-on and down on turn-off ("breathing" transitions).
- Drives the active-low board LEDs directly; pattern sources stay purely logical (1 = lit).

---
 rtl/led_fade_if.sv | 21 ++
 rtl/led_fade_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_fade_if.sv
// Pattern-in / LED-pins-out bundle for led_fade_driver.
// The master side is the pattern source; the slave side is the driver.
interface led_fade_if #(
  parameter int led_number = 6
);
  logic [led_number-1:0] leds_in;
  logic [led_number-1:0] leds;
  logic                  fade_busy;

  modport master (
    output leds_in,
    input  leds,
    input  fade_busy
  );

  modport slave (
    input  leds_in,
    output leds,
    output fade_busy
  );
endinterface

// File: rtl/led_fade_driver.sv
// PWM LED driver with per-channel breathing fade; drives active-low board pins.
// Define LED_FADE_GAMMA_EN for a registered square-law brightness curve.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_OFF  | dark, duty held at 0, waiting for req
// ST_UP   | ramping brighter, one duty step per step_tick
// ST_ON   | fully lit, duty held at P
// ST_DOWN | ramping darker, one duty step per step_tick
module led_fade_driver #(
  parameter int led_number  = 6,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 105000
) (
  input  logic        clk,
  input  logic        rst,
  led_fade_if.slave   bus
);

  localparam logic [PWM_BITS-1:0] P        = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST = P - PWM_BITS'(1);
  localparam int                  STEP_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } ch_state_e;

  logic [led_number-1:0] req_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic                  step_tick;

  ch_state_e             state_q [led_number];
  ch_state_e             state_d [led_number];
  logic [PWM_BITS-1:0]   duty_q  [led_number];
  logic [PWM_BITS-1:0]   duty_d  [led_number];
  logic [PWM_BITS-1:0]   eff_duty [led_number];

  logic [led_number-1:0] leds_q, leds_d;
  logic                  fade_busy_q, fade_busy_d;

  // Shared timebase: PWM period is P clocks so duty P means always lit.
  always_comb begin
    pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    step_tick  = (step_cnt_q == STEP_LAST);
    step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_W'(1);
  end

  always_comb begin
    for (int i = 0; i < led_number; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      case (state_q[i])
        ST_OFF: begin
          duty_d[i] = '0;
          if (req_q[i]) state_d[i] = ST_UP;
        end
        ST_UP: begin
          // A reversal takes priority over a coincident tick; no step that clock.
          if (!req_q[i]) begin
            state_d[i] = ST_DOWN;
          end else if (duty_q[i] == P) begin
            state_d[i] = ST_ON;
          end else if (step_tick) begin
            duty_d[i] = duty_q[i] + PWM_BITS'(1);
            if (duty_q[i] == PWM_LAST) state_d[i] = ST_ON;
          end
        end
        ST_ON: begin
          duty_d[i] = P;
          if (!req_q[i]) state_d[i] = ST_DOWN;
        end
        ST_DOWN: begin
          if (req_q[i]) begin
            state_d[i] = ST_UP;
          end else if (duty_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else if (step_tick) begin
            duty_d[i] = duty_q[i] - PWM_BITS'(1);
            if (duty_q[i] == PWM_BITS'(1)) state_d[i] = ST_OFF;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          duty_d[i]  = '0;
        end
      endcase
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [PWM_BITS-1:0]   eff_q [led_number];
  logic [PWM_BITS-1:0]   eff_d [led_number];
  logic [2*PWM_BITS-1:0] sq;

  // Square law keeps full scale exact: P*P>>PWM_BITS would fall one short.
  always_comb begin
    sq = '0;
    for (int i = 0; i < led_number; i++) begin
      sq       = {{PWM_BITS{1'b0}}, duty_q[i]} * {{PWM_BITS{1'b0}}, duty_q[i]};
      eff_d[i] = (duty_q[i] == P) ? P : sq[2*PWM_BITS-1:PWM_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < led_number; i++) eff_q[i] <= '0;
    end else begin
      for (int i = 0; i < led_number; i++) eff_q[i] <= eff_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < led_number; i++) eff_duty[i] = eff_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < led_number; i++) eff_duty[i] = duty_q[i];
  end
`endif

  always_comb begin
    fade_busy_d = 1'b0;
    leds_d      = '1;
    for (int i = 0; i < led_number; i++) begin
      leds_d[i] = ~(eff_duty[i] > pwm_cnt_q);
      if (state_q[i] == ST_UP || state_q[i] == ST_DOWN) fade_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      pwm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      leds_q      <= '1;
      fade_busy_q <= 1'b0;
      for (int i = 0; i < led_number; i++) begin
        state_q[i] <= ST_OFF;
        duty_q[i]  <= '0;
      end
    end else begin
      req_q       <= bus.leds_in;
      pwm_cnt_q   <= pwm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      leds_q      <= leds_d;
      fade_busy_q <= fade_busy_d;
      for (int i = 0; i < led_number; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  assign bus.leds      = leds_q;
  assign bus.fade_busy = fade_busy_q;

endmodule
